// File: rtl/tuner_pkg.sv
// Shared definitions for the tuner datapath: default sample width,
// default silence timeout, idle counter width and the smoother state encoding.
package tuner_pkg;

    localparam int PERIOD_W_DEF    = 34;
    localparam int TIMEOUT_CYC_DEF = 50000000;
    localparam int IDLE_CNT_W      = 34;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } state_e;

endpackage

// File: rtl/period_ring.sv
// N-entry ring of period samples with a running sum.
// clear_i empties the ring, load_i empties it and stores sample_i as entry 0,
// push_i overwrites the oldest entry and keeps sum = sum + new - oldest.
// sum_nxt_o is the sum as it will be after this cycle's operation, so the
// caller can register an average in the same cycle as the push.
module period_ring #(
    parameter int PERIOD_W = 34,
    parameter int AVG_LOG2 = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_i,
    input  logic                         load_i,
    input  logic                         push_i,
    input  logic [PERIOD_W-1:0]          sample_i,
    output logic [PERIOD_W+AVG_LOG2-1:0] sum_nxt_o
);

    localparam int N     = 1 << AVG_LOG2;
    localparam int SUM_W = PERIOD_W + AVG_LOG2;

    logic [PERIOD_W-1:0] entry_q [N];
    logic [PERIOD_W-1:0] entry_d [N];
    logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [PERIOD_W-1:0] oldest_s;

    // The write pointer always addresses the oldest entry (zero while filling).
    assign oldest_s  = entry_q[wr_ptr_q];
    assign sum_nxt_o = sum_d;

    // Next-state of the ring contents, pointer and running sum.
    always_comb begin
        entry_d  = entry_q;
        wr_ptr_d = wr_ptr_q;
        sum_d    = sum_q;
        if (clear_i || load_i) begin
            for (int i = 0; i < N; i++) begin
                entry_d[i] = {PERIOD_W{1'b0}};
            end
            if (load_i) begin
                entry_d[0] = sample_i;
                wr_ptr_d   = AVG_LOG2'(1);
                sum_d      = SUM_W'(sample_i);
            end else begin
                wr_ptr_d   = {AVG_LOG2{1'b0}};
                sum_d      = {SUM_W{1'b0}};
            end
        end else if (push_i) begin
            entry_d[wr_ptr_q] = sample_i;
            wr_ptr_d          = wr_ptr_q + AVG_LOG2'(1);
            sum_d             = sum_q + SUM_W'(sample_i) - SUM_W'(oldest_s);
        end else begin
            sum_d = sum_q;
        end
    end

    // Ring storage, pointer and sum registers; reset empties everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_q  <= '{default: {PERIOD_W{1'b0}}};
            wr_ptr_q <= {AVG_LOG2{1'b0}};
            sum_q    <= {SUM_W{1'b0}};
        end else begin
            entry_q  <= entry_d;
            wr_ptr_q <= wr_ptr_d;
            sum_q    <= sum_d;
        end
    end

endmodule

// File: rtl/period_smoother.sv
// Period smoother: averages the last N raw period measurements, locks once
// N samples are collected and drops to zero output on silence (a zero
// sample or TIMEOUT_CYC cycles without any sample).
// Optional feature macro PERIOD_OUTLIER_REJECT_EN: while locked, samples
// outside avg +/- avg>>TOL_SHIFT are ignored once, and a second consecutive
// outlier restarts acquisition from that sample.
module period_smoother
    import tuner_pkg::*;
#(
    parameter int PERIOD_W    = PERIOD_W_DEF,
    parameter int AVG_LOG2    = 2,
    parameter int TOL_SHIFT   = 3,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic                period_vld,
    output logic [PERIOD_W-1:0] period_out,
    output logic                period_out_vld,
    output logic                locked
);

    localparam int N      = 1 << AVG_LOG2;
    localparam int SUM_W  = PERIOD_W + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;

    // A tolerance shift at or beyond the sample width leaves a zero window;
    // such a configuration is not meant to be built and generates nothing.
    if (TOL_SHIFT >= PERIOD_W) begin : g_tol_unsupported
    end

    state_e                state_q, state_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic [PERIOD_W-1:0]   period_out_q, period_out_d;
    logic                  out_vld_q, out_vld_d;
    logic                  locked_q, locked_d;
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic                  sample_s, zero_s, timeout_s, silence_s;
    logic                  ring_clear_s, ring_load_s, ring_push_s;
    logic [SUM_W-1:0]      sum_nxt_s;

    assign sample_s  = period_vld && (period_in != {PERIOD_W{1'b0}});
    assign zero_s    = period_vld && (period_in == {PERIOD_W{1'b0}});
    // A sample on the timeout cycle wins: timeout only fires with no sample.
    assign timeout_s = !period_vld && (idle_cnt_q == IDLE_CNT_W'(TIMEOUT_CYC - 1));
    assign silence_s = zero_s || timeout_s;

`ifdef PERIOD_OUTLIER_REJECT_EN
    logic [1:0]          rej_cnt_q, rej_cnt_d;
    logic [PERIOD_W-1:0] diff_s;
    logic                accept_s;

    assign diff_s   = (period_in >= period_out_q) ? (period_in - period_out_q)
                                                  : (period_out_q - period_in);
    assign accept_s = (diff_s <= (period_out_q >> TOL_SHIFT));
`endif

    // Idle counter: restarts on any sample and after each timeout.
    always_comb begin
        if (period_vld || timeout_s) begin
            idle_cnt_d = {IDLE_CNT_W{1'b0}};
        end else begin
            idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
        end
    end

    // State machine: next state, ring controls and next output values.
    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        period_out_d = period_out_q;
        out_vld_d    = 1'b0;
        ring_clear_s = 1'b0;
        ring_load_s  = 1'b0;
        ring_push_s  = 1'b0;
`ifdef PERIOD_OUTLIER_REJECT_EN
        rej_cnt_d    = rej_cnt_q;
`endif
        if (silence_s) begin
            state_d      = IDLE;
            fill_d       = {FILL_W{1'b0}};
            period_out_d = {PERIOD_W{1'b0}};
            out_vld_d    = (period_out_q != {PERIOD_W{1'b0}});
            ring_clear_s = 1'b1;
`ifdef PERIOD_OUTLIER_REJECT_EN
            rej_cnt_d    = 2'd0;
`endif
        end else if (sample_s) begin
            case (state_q)
                IDLE: begin
                    ring_load_s = 1'b1;
                    fill_d      = FILL_W'(1);
                    state_d     = ACQUIRE;
                end
                ACQUIRE: begin
                    ring_push_s = 1'b1;
                    fill_d      = fill_q + FILL_W'(1);
                    if (fill_q == FILL_W'(N - 1)) begin
                        state_d      = TRACK;
                        period_out_d = PERIOD_W'(sum_nxt_s >> AVG_LOG2);
                        out_vld_d    = 1'b1;
                    end else begin
                        state_d      = ACQUIRE;
                    end
                end
                TRACK: begin
`ifdef PERIOD_OUTLIER_REJECT_EN
                    if (accept_s) begin
                        ring_push_s  = 1'b1;
                        period_out_d = PERIOD_W'(sum_nxt_s >> AVG_LOG2);
                        out_vld_d    = 1'b1;
                        rej_cnt_d    = 2'd0;
                    end else if (rej_cnt_q == 2'd0) begin
                        rej_cnt_d    = rej_cnt_q + 2'd1;
                    end else begin
                        ring_load_s  = 1'b1;
                        fill_d       = FILL_W'(1);
                        state_d      = ACQUIRE;
                        rej_cnt_d    = 2'd0;
                    end
`else
                    ring_push_s  = 1'b1;
                    period_out_d = PERIOD_W'(sum_nxt_s >> AVG_LOG2);
                    out_vld_d    = 1'b1;
`endif
                end
                default: begin
                    state_d      = IDLE;
                    fill_d       = {FILL_W{1'b0}};
                    ring_clear_s = 1'b1;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        locked_d = (state_d == TRACK);
    end

    period_ring #(
        .PERIOD_W (PERIOD_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (ring_clear_s),
        .load_i    (ring_load_s),
        .push_i    (ring_push_s),
        .sample_i  (period_in),
        .sum_nxt_o (sum_nxt_s)
    );

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            fill_q       <= {FILL_W{1'b0}};
            period_out_q <= {PERIOD_W{1'b0}};
            out_vld_q    <= 1'b0;
            locked_q     <= 1'b0;
            idle_cnt_q   <= {IDLE_CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            period_out_q <= period_out_d;
            out_vld_q    <= out_vld_d;
            locked_q     <= locked_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

`ifdef PERIOD_OUTLIER_REJECT_EN
    // Consecutive-outlier counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rej_cnt_q <= 2'd0;
        end else begin
            rej_cnt_q <= rej_cnt_d;
        end
    end
`endif

    assign period_out     = period_out_q;
    assign period_out_vld = out_vld_q;
    assign locked         = locked_q;

endmodule

// File: doc/period_smoother.md
PERIOD_SMOOTHER -- requirements
Module: period_smoother

Interface
REQ-001 The block SHALL expose parameter PERIOD_W, default 34, meaning the width of period samples in clk cycles.
REQ-002 The block SHALL expose parameter AVG_LOG2, default 2, meaning log2 of the averaging depth N (N=4).
REQ-003 The block SHALL expose parameter TOL_SHIFT, default 3, meaning the outlier tolerance window of avg>>TOL_SHIFT (12.5%).
REQ-004 The block SHALL expose parameter TIMEOUT_CYC, default 50000000, meaning the number of idle cycles that declares silence.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, the same divided clock that drives the period measurement stage.
REQ-006 The block SHALL have port rst, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-007 The block SHALL have port period_in, input, PERIOD_W bits: the raw period measurement from the upstream period measurement stage.
REQ-008 The block SHALL have port period_vld, input, 1 bit: a one-cycle pulse marking period_in as a new measurement.
REQ-009 The block SHALL have port period_out, output, PERIOD_W bits: the smoothed period delivered to the note display stage.
REQ-010 The block SHALL have port period_out_vld, output, 1 bit: a one-cycle pulse on every period_out update.
REQ-011 The block SHALL have port locked, output, 1 bit: high while in TRACK.

Function
REQ-012 The state machine SHALL have exactly three states: IDLE, ACQUIRE and TRACK.
REQ-013 In IDLE, a period_vld with nonzero period_in SHALL clear the ring buffer, store the sample as entry 0 (fill=1) and go to ACQUIRE.
REQ-014 In ACQUIRE, each nonzero sample SHALL be stored and increment fill; when fill reaches N, the block SHALL go to TRACK.
REQ-015 On entering TRACK, the block SHALL drive period_out = sum>>AVG_LOG2, pulse period_out_vld and set locked.
REQ-016 In TRACK, an accepted sample SHALL overwrite the oldest entry and set sum = sum + new - oldest.
REQ-017 In TRACK, after each accepted sample, period_out SHALL be updated and period_out_vld pulsed exactly 1 cycle after the period_vld.
REQ-018 In TRACK, a sample SHALL be accepted iff |period_in - period_out| <= period_out>>TOL_SHIFT (inclusive boundary).
REQ-019 A rejected sample SHALL leave the buffer and outputs unchanged and increment rej_cnt.
REQ-020 An accepted sample SHALL clear rej_cnt.
REQ-021 A second consecutive rejected sample SHALL flush the buffer, load that sample as the fill=1 entry, clear locked and go to ACQUIRE.
REQ-022 A period_vld with period_in==0 in any state SHALL be treated as silence.
REQ-023 A 34-bit idle counter SHALL count cycles without period_vld; reaching TIMEOUT_CYC in any state SHALL also be treated as silence.
REQ-024 On silence, the block SHALL go to IDLE, drive period_out = 0, pulse period_out_vld once (only if period_out was nonzero) and clear locked.
REQ-025 If period_vld coincides with the timeout cycle, the sample SHALL take priority and the idle counter SHALL restart at 0.
REQ-026 The sum register SHALL be PERIOD_W+AVG_LOG2 bits wide with no overflow, and the division SHALL be a truncating shift.
REQ-027 The ring write pointer SHALL be AVG_LOG2 bits wide and wrap from N-1 to 0.

Reset
REQ-028 Asserting rst low at any time, including mid-ACQUIRE or mid-TRACK, SHALL force IDLE, period_out=0, period_out_vld=0, locked=0, sum=0, fill=0, rej_cnt=0, the idle counter to 0 and every buffer entry to 0.
REQ-029 The first sample accepted after rst deassertion SHALL be any period_vld on the first clk edge at or after deassertion.

Configuration
REQ-030 With macro PERIOD_OUTLIER_REJECT_EN defined, REQ-018 to REQ-021 SHALL apply.
REQ-031 Without PERIOD_OUTLIER_REJECT_EN, every nonzero sample in TRACK SHALL be accepted, and rej_cnt and the comparator SHALL not be synthesized.

Structure
REQ-032 Package tuner_pkg SHALL hold PERIOD_W_DEF=34, the state encoding IDLE/ACQUIRE/TRACK and TIMEOUT_CYC_DEF.
REQ-033 Sub-module period_ring SHALL implement the N-entry buffer, write pointer, oldest-entry readout and running sum with clear/load/push controls; the FSM, tolerance check and timeout SHALL stay in period_smoother.

Verification
REQ-034 Reset then 4 pulses of 12135000 -> period_out=12135000 with vld 1 cycle after the 4th pulse, and locked=1.
REQ-035 Locked at 12135000, then pulses 12135000, 12135000, 12135000, 12500000 -> period_out=12226250 after the last pulse.
REQ-036 Locked at 13621000, then a single 20000000 sample, then 13621000 -> no update on the outlier and locked kept; with the macro undefined, the outlier is averaged in.
REQ-037 Locked, then two consecutive samples of 6000000 -> locked=0, state ACQUIRE with fill=1; 3 more 6000000 samples -> period_out=6000000 and locked=1.
REQ-038 Locked, then no period_vld for TIMEOUT_CYC cycles (TIMEOUT_CYC=100 in the bench) -> period_out=0 with a single vld pulse and IDLE; separately, a period_in=0 pulse gives the same result.
REQ-039 Assert rst low between the 2nd and 3rd acquisition samples -> all outputs 0 immediately; afterwards 4 fresh samples are needed to lock.
